// File: rtl/spi_master_xfer_pkg.sv
// rtl/spi_master_xfer_pkg.sv - shared FSM encoding and SPI idle levels for the SPI initiator
package spi_master_xfer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam logic SCK_IDLE  = 1'b0;
    localparam logic MOSI_IDLE = 1'b1;
    localparam logic SS_IDLE   = 1'b1;

endpackage

// File: rtl/spi_master_xfer_clkgen.sv
// rtl/spi_master_xfer_clkgen.sv - sck half-period counter with one-cycle rise/fall strobes
module spi_master_xfer_clkgen #(
    parameter int DIV_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [DIV_W-1:0] start_div,
    input  logic             run,
    input  logic [DIV_W-1:0] div,
    input  logic             level,
    output logic             rise,
    output logic             fall
);

    logic [DIV_W-1:0] cnt;
    logic             phase_end;

    // A phase lasts div+1 clocks: the counter runs div..0 and reloads on the last one.
    assign phase_end = run && (cnt == '0);
    assign rise      = phase_end && !level;
    assign fall      = phase_end && level;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (start) begin
            cnt <= start_div;
        end else if (phase_end) begin
            cnt <= div;
        end else if (run) begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/spi_master_xfer.sv
// rtl/spi_master_xfer.sv - mode-0 SPI initiator: one command in, one response out per transfer
module spi_master_xfer
    import spi_master_xfer_pkg::*;
#(
    parameter int MAX_BITS = 16,
    parameter int SS_NUM   = 8,
    parameter int DIV_W    = 8,
    localparam int LEN_W   = $clog2(MAX_BITS + 1),
    localparam int SEL_W   = $clog2(SS_NUM)
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [MAX_BITS-1:0] req_data,
    input  logic [LEN_W-1:0]    req_len,
    input  logic [SEL_W-1:0]    req_ss,
    input  logic [DIV_W-1:0]    req_div,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [MAX_BITS-1:0] rsp_data,
    output logic                busy,
    output logic                spi_sck,
    output logic [SS_NUM-1:0]   spi_ss,
    output logic                spi_mosi,
    input  logic                spi_miso
);

    state_t              state, state_d;
    logic [MAX_BITS-1:0] tx_sr, tx_d, rx_sr, rx_d, rsp_data_d, tx_aligned;
    logic [LEN_W-1:0]    bits_left, bits_d, len_eff;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [SS_NUM-1:0]   ss_d, ss_decode;
    logic                sck_d, mosi_d, rsp_valid_d, ready_d, busy_d;
    logic                accept, rise, fall, run;

    assign accept     = req_valid && req_ready;
    assign len_eff    = (req_len == '0) ? LEN_W'(MAX_BITS) : req_len;
    // Left-align the payload so the first bit to send is always the MSB of the shifter.
    assign tx_aligned = req_data << (LEN_W'(MAX_BITS) - len_eff);
    assign run        = (state == ST_SETUP) || (state == ST_HIGH) || (state == ST_LOW);

    always_comb begin
        for (int i = 0; i < SS_NUM; i++) begin
            ss_decode[i] = (int'(req_ss) == i) ? !SS_IDLE : SS_IDLE;
        end
    end

    spi_master_xfer_clkgen #(.DIV_W(DIV_W)) u_clkgen (
        .clock     (clock),
        .reset     (reset),
        .start     (accept),
        .start_div (req_div),
        .run       (run),
        .div       (div_q),
        .level     (spi_sck),
        .rise      (rise),
        .fall      (fall)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            tx_sr     <= '0;
            rx_sr     <= '0;
            bits_left <= '0;
            div_q     <= '0;
            spi_sck   <= SCK_IDLE;
            spi_ss    <= {SS_NUM{SS_IDLE}};
            spi_mosi  <= MOSI_IDLE;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            req_ready <= 1'b1;
            busy      <= 1'b0;
        end else begin
            state     <= state_d;
            tx_sr     <= tx_d;
            rx_sr     <= rx_d;
            bits_left <= bits_d;
            div_q     <= div_d;
            spi_sck   <= sck_d;
            spi_ss    <= ss_d;
            spi_mosi  <= mosi_d;
            rsp_valid <= rsp_valid_d;
            rsp_data  <= rsp_data_d;
            req_ready <= ready_d;
            busy      <= busy_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            ST_IDLE:  if (accept) state_d = ST_SETUP;
            ST_SETUP: if (rise) state_d = ST_HIGH;
            ST_HIGH:  if (fall) state_d = ST_LOW;
            ST_LOW:   if (rise) state_d = (bits_left != '0) ? ST_HIGH : ST_DONE;
            ST_DONE:  if (rsp_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        tx_d        = tx_sr;
        rx_d        = rx_sr;
        bits_d      = bits_left;
        div_d       = div_q;
        sck_d       = spi_sck;
        ss_d        = spi_ss;
        mosi_d      = spi_mosi;
        rsp_valid_d = rsp_valid;
        rsp_data_d  = rsp_data;
        ready_d     = req_ready;
        busy_d      = busy;
        case (state)
            ST_IDLE: if (accept) begin
                tx_d    = tx_aligned;
                rx_d    = '0;
                bits_d  = len_eff;
                div_d   = req_div;
                ss_d    = ss_decode;
                mosi_d  = tx_aligned[MAX_BITS-1];
                ready_d = 1'b0;
                busy_d  = 1'b1;
            end
            ST_SETUP, ST_LOW: if (rise) begin
                // The low phase after the last bit is the ss hold time; no further sck edge.
                if (state == ST_LOW && bits_left == '0) begin
                    ss_d        = {SS_NUM{SS_IDLE}};
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = rx_sr;
                end else begin
                    sck_d  = 1'b1;
                    rx_d   = {rx_sr[MAX_BITS-2:0], spi_miso};
                    tx_d   = tx_sr << 1;
                    bits_d = bits_left - LEN_W'(1);
                end
            end
            ST_HIGH: if (fall) begin
                sck_d  = SCK_IDLE;
                mosi_d = (bits_left != '0) ? tx_sr[MAX_BITS-1] : MOSI_IDLE;
            end
            ST_DONE: if (rsp_ready) begin
                rsp_valid_d = 1'b0;
                ready_d     = 1'b1;
                busy_d      = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_spi_master_xfer.sv
// tb/tb_spi_master_xfer.sv - self-checking bench for spi_master_xfer with a behavioural SPI slave
module tb_spi_master_xfer;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [15:0] req_data = '0;
    logic [4:0]  req_len = '0;
    logic [2:0]  req_ss = '0;
    logic [7:0]  req_div = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [15:0] rsp_data;
    logic        busy;
    logic        spi_sck;
    logic [7:0]  spi_ss;
    logic        spi_mosi;
    logic        spi_miso;

    int checks = 0;
    int failures = 0;
    localparam int BUDGET = 20000;

    always #5 clock = ~clock;

    spi_master_xfer #(.MAX_BITS(16), .SS_NUM(8), .DIV_W(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_len   (req_len),
        .req_ss    (req_ss),
        .req_div   (req_div),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .spi_sck   (spi_sck),
        .spi_ss    (spi_ss),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso)
    );

    // Slave: 0 = loopback, 1 = inverting echo, 2 = shifts out its own word MSB first
    int          slv_mode = 0;
    logic [15:0] slv_sr = '0;
    logic [15:0] slv_rx = '0;
    int          rise_cnt = 0;
    int          ss_low_cnt = 0;
    int          period_bad = 0;
    bit          multi_low = 1'b0;
    logic [7:0]  ss_seen = 8'hFF;
    time         last_rise = 0;
    time         exp_period = 20;

    assign spi_miso = (slv_mode == 0) ? spi_mosi : (slv_mode == 1) ? ~spi_mosi : slv_sr[15];

    always @(posedge spi_sck) begin
        if (rise_cnt > 0 && ($time - last_rise) != exp_period) period_bad++;
        last_rise = $time;
        rise_cnt++;
        slv_rx = {slv_rx[14:0], spi_mosi};
    end

    always @(negedge spi_sck) slv_sr = {slv_sr[14:0], 1'b0};

    always @(negedge clock) begin
        if (spi_ss !== 8'hFF) begin
            ss_low_cnt++;
            ss_seen = spi_ss;
            if ($countones(~spi_ss) != 1) multi_low = 1'b1;
        end
    end

    task automatic clear_monitors(input logic [7:0] dv);
        rise_cnt   = 0;
        ss_low_cnt = 0;
        period_bad = 0;
        multi_low  = 1'b0;
        ss_seen    = 8'hFF;
        slv_rx     = '0;
        exp_period = time'(2 * (int'(dv) + 1) * 10);
    endtask

    task automatic issue(input logic [15:0] d, input logic [4:0] l, input logic [2:0] s,
                         input logic [7:0] dv, output bit ok);
        int t = 0;
        @(negedge clock);
        req_data = d; req_len = l; req_ss = s; req_div = dv; req_valid = 1'b1;
        while (!req_ready && t < BUDGET) begin
            @(negedge clock);
            t++;
        end
        clear_monitors(dv);
        @(posedge clock);
        @(negedge clock);
        // Scramble the command inputs: the transfer in flight must ignore them.
        req_valid = 1'b0;
        req_data = 16'($urandom); req_len = 5'($urandom); req_ss = 3'($urandom); req_div = 8'($urandom);
        ok = (t < BUDGET);
    endtask

    task automatic collect(output logic [15:0] r, output bit ok);
        int t = 0;
        while (!rsp_valid && t < BUDGET) begin
            @(negedge clock);
            t++;
        end
        ok = rsp_valid;
        r = rsp_data;
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
    endtask

    function automatic logic [15:0] model_rsp(input int mode, input logic [15:0] d,
                                              input logic [15:0] w, input int le);
        logic [15:0] mask;
        mask = 16'((32'd1 << le) - 1);
        case (mode)
            0:       return d & mask;
            1:       return ~d & mask;
            default: return w >> (16 - le);
        endcase
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        checks++;
        if ({req_ready, rsp_valid, busy, spi_sck, spi_mosi, spi_ss, rsp_data} !== {5'b10001, 8'hFF, 16'h0000}) begin
            failures++;
            $display("FAIL reset_values got=%h exp=%h",
                     {req_ready, rsp_valid, busy, spi_sck, spi_mosi, spi_ss, rsp_data}, {5'b10001, 8'hFF, 16'h0000});
        end
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_bitrev;
        bit ok1, ok2;
        logic [15:0] r;
        slv_mode = 1;
        issue(16'h00B2, 5'd16, 3'd0, 8'd0, ok1);
        collect(r, ok2);
        checks++; if (!(ok1 && ok2)) begin failures++; $display("FAIL bitrev_timeout got=%0d exp=1", ok1 && ok2); end
        checks++; if (r !== 16'hFF4D) begin failures++; $display("FAIL bitrev_data got=%h exp=ff4d", r); end
        checks++; if (rise_cnt != 16) begin failures++; $display("FAIL bitrev_rises got=%0d exp=16", rise_cnt); end
        checks++; if (ss_low_cnt != 33) begin failures++; $display("FAIL bitrev_ss_low got=%0d exp=33", ss_low_cnt); end
        checks++; if (ss_seen !== 8'hFE) begin failures++; $display("FAIL bitrev_ss_line got=%h exp=fe", ss_seen); end
    endtask

    task automatic test_div3;
        bit ok1, ok2;
        logic [15:0] r, d;
        slv_mode = 0;
        d = 16'($urandom);
        issue(d, 5'd8, 3'd0, 8'd3, ok1);
        collect(r, ok2);
        checks++; if (!(ok1 && ok2)) begin failures++; $display("FAIL div3_timeout got=%0d exp=1", ok1 && ok2); end
        checks++; if (r !== {8'h00, d[7:0]}) begin failures++; $display("FAIL div3_data got=%h exp=%h", r, {8'h00, d[7:0]}); end
        checks++; if (period_bad != 0) begin failures++; $display("FAIL div3_sck_period got=%0d bad exp=0", period_bad); end
        checks++; if (ss_low_cnt != 68) begin failures++; $display("FAIL div3_ss_low got=%0d exp=68", ss_low_cnt); end
        checks++; if (rise_cnt != 8) begin failures++; $display("FAIL div3_rises got=%0d exp=8", rise_cnt); end
    endtask

    task automatic test_len0;
        bit ok1, ok2;
        logic [15:0] r;
        slv_mode = 0;
        issue(16'h1234, 5'd0, 3'd0, 8'd0, ok1);
        collect(r, ok2);
        checks++; if (!(ok1 && ok2)) begin failures++; $display("FAIL len0_timeout got=%0d exp=1", ok1 && ok2); end
        checks++; if (r !== 16'h1234) begin failures++; $display("FAIL len0_data got=%h exp=1234", r); end
        checks++; if (rise_cnt != 16) begin failures++; $display("FAIL len0_rises got=%0d exp=16", rise_cnt); end
    endtask

    task automatic test_ss_select;
        bit ok1, ok2;
        logic [15:0] r;
        slv_mode = 0;
        @(negedge clock);
        checks++; if (spi_ss !== 8'hFF) begin failures++; $display("FAIL ss_before got=%h exp=ff", spi_ss); end
        issue(16'($urandom), 5'd5, 3'd2, 8'd1, ok1);
        collect(r, ok2);
        checks++; if (ss_seen !== 8'b1111_1011 || multi_low) begin
            failures++; $display("FAIL ss_during got=%h multi=%0d exp=fb", ss_seen, multi_low);
        end
        checks++; if (spi_ss !== 8'hFF || !ok2) begin failures++; $display("FAIL ss_after got=%h exp=ff", spi_ss); end
    endtask

    task automatic test_backpressure;
        bit ok1, ok2;
        int t = 0;
        int stable_bad = 0;
        logic [15:0] d1, d2, r;
        slv_mode = 0;
        d1 = 16'($urandom);
        d2 = 16'($urandom);
        issue(d1, 5'd12, 3'd0, 8'd0, ok1);
        while (!rsp_valid && t < BUDGET) begin @(negedge clock); t++; end
        req_data = d2; req_len = 5'd16; req_ss = 3'd1; req_div = 8'd1; req_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (rsp_valid !== 1'b1 || rsp_data !== {4'h0, d1[11:0]} || req_ready !== 1'b0 || busy !== 1'b1)
                stable_bad++;
            @(negedge clock);
        end
        checks++; if (stable_bad != 0 || !ok1) begin failures++; $display("FAIL hold_stable got=%0d bad cycles exp=0", stable_bad); end
        rsp_ready = 1'b1;
        @(negedge clock);
        rsp_ready = 1'b0;
        checks++; if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            failures++; $display("FAIL after_handshake got=%b%b exp=10", req_ready, rsp_valid);
        end
        clear_monitors(8'd1);
        @(negedge clock);
        req_valid = 1'b0;
        checks++; if (busy !== 1'b1 || req_ready !== 1'b0) begin
            failures++; $display("FAIL second_accept got=%b%b exp=10", busy, req_ready);
        end
        collect(r, ok2);
        checks++; if (r !== d2 || !ok2) begin failures++; $display("FAIL second_data got=%h exp=%h", r, d2); end
        checks++; if (rise_cnt != 16) begin failures++; $display("FAIL second_rises got=%0d exp=16", rise_cnt); end
    endtask

    task automatic test_reset_mid;
        bit ok1, ok2;
        int t = 0;
        logic [15:0] r, d;
        slv_mode = 0;
        issue(16'($urandom), 5'd10, 3'd3, 8'd2, ok1);
        while (rise_cnt < 5 && t < BUDGET) begin @(negedge clock); t++; end
        reset = 1'b1;
        #1;
        checks++; if ({spi_sck, spi_ss, spi_mosi, rsp_valid, busy, req_ready} !== {1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1} || !ok1) begin
            failures++; $display("FAIL reset_mid got=%h exp=%h",
                {spi_sck, spi_ss, spi_mosi, rsp_valid, busy, req_ready}, {1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1});
        end
        @(negedge clock);
        reset = 1'b0;
        d = 16'($urandom);
        issue(d, 5'd7, 3'd0, 8'd0, ok1);
        collect(r, ok2);
        checks++; if (r !== {9'h0, d[6:0]} || !(ok1 && ok2)) begin
            failures++; $display("FAIL after_reset_data got=%h exp=%h", r, {9'h0, d[6:0]});
        end
    endtask

    task automatic test_random;
        bit ok1, ok2;
        logic [15:0] r, d, w, mask;
        logic [4:0] l;
        logic [2:0] s;
        logic [7:0] dv;
        int le;
        for (int n = 0; n < 25; n++) begin
            slv_mode = n % 3;
            d = 16'($urandom); w = 16'($urandom);
            l = 5'($urandom_range(0, 16)); s = 3'($urandom); dv = 8'($urandom_range(0, 3));
            le = (l == 0) ? 16 : int'(l);
            mask = 16'((32'd1 << le) - 1);
            slv_sr = w;
            issue(d, l, s, dv, ok1);
            collect(r, ok2);
            checks++; if (r !== model_rsp(slv_mode, d, w, le) || !(ok1 && ok2)) begin
                failures++; $display("FAIL rand%0d_data got=%h exp=%h", n, r, model_rsp(slv_mode, d, w, le));
            end
            checks++; if (slv_rx !== (d & mask)) begin
                failures++; $display("FAIL rand%0d_mosi got=%h exp=%h", n, slv_rx, d & mask);
            end
            checks++; if (rise_cnt != le || period_bad != 0) begin
                failures++; $display("FAIL rand%0d_sck got=%0d rises %0d bad exp=%0d rises", n, rise_cnt, period_bad, le);
            end
            checks++; if (ss_low_cnt != (2 * le + 1) * (int'(dv) + 1) || ss_seen !== ~(8'h01 << s) || multi_low) begin
                failures++; $display("FAIL rand%0d_ss got=%0d/%h exp=%0d/%h", n, ss_low_cnt, ss_seen,
                                     (2 * le + 1) * (int'(dv) + 1), ~(8'h01 << s));
            end
            checks++; if ({busy, req_ready, spi_sck, spi_mosi, spi_ss} !== {4'b0101, 8'hFF}) begin
                failures++; $display("FAIL rand%0d_idle got=%h exp=%h", n, {busy, req_ready, spi_sck, spi_mosi, spi_ss}, {4'b0101, 8'hFF});
            end
        end
    endtask

    initial begin
        test_reset();
        test_bitrev();
        test_div3();
        test_len0();
        test_ss_select();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
